// File: rtl/mmio_port_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_responder_if
// Brief    : Data-memory bus bundle shared by the CPU and the MMIO responder.
// Revision : 1.0
// ============================================================================
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  Hit
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output Hit
    );
endinterface
`default_nettype wire

// File: rtl/mmio_port_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_port_responder
// Brief    : 16-byte MMIO window: output port, synchronized input port,
//            sticky change flag and saturating change counter.
// Revision : 1.0
// ============================================================================
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0040,
    parameter int          IN_WIDTH  = 8,
    parameter int          CNT_WIDTH = 16
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    mmio_port_responder_if.slave      bus,
    input  wire logic [IN_WIDTH-1:0]  PortIn,
    output logic      [31:0]          PortOut
);

    localparam logic [1:0]           c_PORT_OUT = 2'd0;
    localparam logic [1:0]           c_PORT_IN  = 2'd1;
    localparam logic [1:0]           c_STATUS   = 2'd2;
    localparam logic [1:0]           c_COUNT    = 2'd3;
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    logic [31:0]          r_port_out;
    logic [IN_WIDTH-1:0]  r_s1;
    logic [IN_WIDTH-1:0]  r_s2;
    logic [IN_WIDTH-1:0]  r_s3;
    logic                 r_changed;
    logic [CNT_WIDTH-1:0] r_count;

    logic       w_hit;
    logic [1:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic       w_change;
    logic       w_status_clr;
    logic       w_unused_addr;

    assign w_hit         = (bus.Address[31:4] == BASE_ADDR[31:4]);
    assign w_off         = bus.Address[3:2];
    assign w_wr          = w_hit && bus.MemWrite;
    assign w_rd          = w_hit && bus.MemRead;
    assign w_change      = (r_s2 != r_s3);
    assign w_unused_addr = ^bus.Address[1:0];

    // A STATUS load acknowledges the flag just like a W1C store does.
    assign w_status_clr = (w_off == c_STATUS) &&
                          ((w_wr && bus.WriteData[0]) || w_rd);

    assign bus.Hit = w_hit;
    assign PortOut = r_port_out;

    always_comb begin
        bus.ReadData = 32'h0;
        if (w_rd) begin
            case (w_off)
                c_PORT_OUT: bus.ReadData = r_port_out;
                c_PORT_IN:  bus.ReadData = 32'(r_s2);
                c_STATUS:   bus.ReadData = {31'h0, r_changed};
                c_COUNT:    bus.ReadData = 32'(r_count);
                default:    bus.ReadData = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out <= 32'h0;
            r_s1       <= '0;
            r_s2       <= '0;
            r_s3       <= '0;
            r_changed  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_s1 <= PortIn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (w_wr && (w_off == c_PORT_OUT)) begin
                r_port_out <= bus.WriteData;
            end

            // Set has priority over any clear in the same cycle.
            if (w_change) begin
                r_changed <= 1'b1;
            end else if (w_status_clr) begin
                r_changed <= 1'b0;
            end

            if (w_wr && (w_off == c_COUNT)) begin
                r_count <= w_change ? c_CNT_ONE : '0;
            end else if (w_change && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
